// File: rtl/glorb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : glorb_pkg
// Description : Shared definitions for the instruction-memory loader:
//               default address/data widths and the loader state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package glorb_pkg;

    // Default instruction memory geometry: 16 words of 8 bits
    localparam int unsigned c_addr_w_default = 4;
    localparam int unsigned c_data_w_default = 8;

    // Loader states; CHECK and FAIL are only reachable with the checksum build
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_RUN   = 3'd3,
        S_FAIL  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/im_loader.sv
`default_nettype none
// ============================================================================
// Module      : im_loader
// Description : Streams a program of 2^ADDR_W words from a valid/ready byte
//               source into instruction memory, then holds the core run
//               enable high. A load_req pulse restarts the load from any
//               state. Optional trailing checksum byte is enabled by the
//               IM_LOADER_CHECKSUM_EN macro (the byte sum of every word
//               plus the checksum must be zero modulo 2^DATA_W).
// Revision    : 1.0 - initial release
// ============================================================================
module im_loader
    import glorb_pkg::*;
#(
    parameter int unsigned ADDR_W = c_addr_w_default,
    parameter int unsigned DATA_W = c_data_w_default
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_req,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [DATA_W-1:0] im_wdata,
    output logic              start,
    output logic              busy,
    output logic              error
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_im_we;
    logic [ADDR_W-1:0] r_im_addr;
    logic [DATA_W-1:0] r_im_wdata;
    logic              r_start;

    logic              w_accept;
    logic              w_cnt_last;

`ifdef IM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] r_sum;
    logic              r_error;
    logic [DATA_W-1:0] w_sum_next;

    // Running byte sum including the byte on the bus this cycle
    assign w_sum_next = r_sum + in_data;
    assign error      = r_error;
`else
    assign error      = 1'b0;
`endif

    // A pending restart request blocks the handshake so the restart wins
    assign in_ready   = ((r_state == S_LOAD) || (r_state == S_CHECK)) && !load_req;
    assign w_accept   = in_valid && in_ready;
    assign w_cnt_last = (r_cnt == {ADDR_W{1'b1}});

    assign busy       = (r_state == S_LOAD) || (r_state == S_CHECK);
    assign im_we      = r_im_we;
    assign im_addr    = r_im_addr;
    assign im_wdata   = r_im_wdata;
    assign start      = r_start;

    // Loader FSM: counts accepted bytes, registers memory writes, gates run enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_im_we    <= 1'b0;
            r_im_addr  <= '0;
            r_im_wdata <= '0;
            r_start    <= 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
            r_sum      <= '0;
            r_error    <= 1'b0;
`endif
        end else begin
            // Write strobe is a single-cycle pulse per accepted byte
            r_im_we <= 1'b0;
            if (load_req) begin
                r_state <= S_LOAD;
                r_cnt   <= '0;
                r_start <= 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
                r_sum   <= '0;
                r_error <= 1'b0;
`endif
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_IDLE;
                    end
                    S_LOAD: begin
                        if (w_accept) begin
                            r_im_we    <= 1'b1;
                            r_im_addr  <= r_cnt;
                            r_im_wdata <= in_data;
                            r_cnt      <= r_cnt + 1'b1;
`ifdef IM_LOADER_CHECKSUM_EN
                            r_sum      <= w_sum_next;
                            if (w_cnt_last) begin
                                r_state <= S_CHECK;
                            end
`else
                            if (w_cnt_last) begin
                                r_state <= S_RUN;
                            end
`endif
                        end
                    end
                    // Entering RUN one edge before start rises lets the final write land first
                    S_RUN: begin
                        r_start <= 1'b1;
                    end
`ifdef IM_LOADER_CHECKSUM_EN
                    // Checksum byte is consumed but never written to memory
                    S_CHECK: begin
                        if (w_accept) begin
                            if (w_sum_next == '0) begin
                                r_state <= S_RUN;
                            end else begin
                                r_state <= S_FAIL;
                                r_error <= 1'b1;
                            end
                        end
                    end
                    S_FAIL: begin
                        r_error <= 1'b1;
                    end
`endif
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_im_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_im_loader
// Description : Directed self-checking bench for im_loader. Exercises
//               back-to-back and throttled loads, restart mid-load, reset
//               mid-load, reload from RUN and, when IM_LOADER_CHECKSUM_EN is
//               defined, checksum pass/fail.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_im_loader;

    logic       clk;
    logic       rst_n;
    logic       load_req;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       im_we;
    logic [3:0] im_addr;
    logic [7:0] im_wdata;
    logic       start;
    logic       busy;
    logic       error;

    int n_checks = 0;
    int n_errors = 0;

    im_loader #(
        .ADDR_W (4),
        .DATA_W (8)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_req (load_req),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .start    (start),
        .busy     (busy),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle load_req pulse; afterwards the loader sits in LOAD at word 0
    task automatic start_load(input string tag);
        load_req = 1'b1;
        #1;
        check_eq({tag, "_rdy_blocked"}, in_ready, 0);
        tick();
        load_req = 1'b0;
        #1;
        check_eq({tag, "_busy"},  busy,     1);
        check_eq({tag, "_rdy"},   in_ready, 1);
        check_eq({tag, "_start"}, start,    0);
        check_eq({tag, "_err"},   error,    0);
        check_eq({tag, "_we"},    im_we,    0);
    endtask

    // Present one byte with in_valid high and check the resulting write
    task automatic send_byte(input logic [7:0] d, input logic [3:0] a, input string tag);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        check_eq({tag, "_we"},    im_we,    1);
        check_eq({tag, "_addr"},  {28'd0, im_addr},  {28'd0, a});
        check_eq({tag, "_data"},  {24'd0, im_wdata}, {24'd0, d});
        check_eq({tag, "_start"}, start,    0);
    endtask

    // After the 16th data byte: optional checksum, then start one cycle later
    task automatic finish_load(input logic [7:0] data_sum, input string tag);
        logic [7:0] csum;
        csum     = 8'h00 - data_sum;
        in_valid = 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
        check_eq({tag, "_busy_chk"}, busy, 1);
        in_valid = 1'b1;
        in_data  = csum;
        tick();
        in_valid = 1'b0;
        check_eq({tag, "_csum_not_written"}, im_we, 0);
`endif
        check_eq({tag, "_busy_end"},   busy,  0);
        check_eq({tag, "_start_early"}, start, 0);
        tick();
        check_eq({tag, "_start"},  start, 1);
        check_eq({tag, "_we_idle"}, im_we, 0);
        check_eq({tag, "_err"},    error, 0);
        check_eq({tag, "_rdy"},    in_ready, 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        load_req = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h5A;

        // Reset state, with a valid byte already on the bus
        #3;
        check_eq("rst_we",    im_we,    0);
        check_eq("rst_addr",  {28'd0, im_addr},  0);
        check_eq("rst_wdata", {24'd0, im_wdata}, 0);
        check_eq("rst_start", start,    0);
        check_eq("rst_busy",  busy,     0);
        check_eq("rst_err",   error,    0);
        check_eq("rst_rdy",   in_ready, 0);
        tick();
        tick();
        #2;
        rst_n = 1'b1;

        // IDLE ignores in_valid
        tick();
        check_eq("idle_we",  im_we,    0);
        check_eq("idle_rdy", in_ready, 0);
        check_eq("idle_busy", busy,    0);
        in_valid = 1'b0;

        // Back-to-back program 0x00..0x0F
        start_load("b2b_req");
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i), 4'(i), $sformatf("b2b_%0d", i));
        end
        finish_load(8'h78, "b2b");

        // RUN ignores in_valid
        in_valid = 1'b1;
        in_data  = 8'hC3;
        tick();
        check_eq("run_ignore_we", im_we, 0);
        check_eq("run_hold_start", start, 1);
        in_valid = 1'b0;

        // Reload from RUN: start drops on the next edge
        load_req = 1'b1;
        #1;
        check_eq("reload_rdy_blocked", in_ready, 0);
        tick();
        load_req = 1'b0;
        check_eq("reload_start_drop", start, 0);
        check_eq("reload_busy",       busy,  1);

        // Throttled load: valid toggles, writes only on handshakes, no skipped addresses
        for (int i = 0; i < 16; i++) begin
            send_byte(8'h30 + 8'(i), 4'(i), $sformatf("tog_%0d", i));
            in_valid = 1'b0;
            if (i < 15) begin
                tick();
                check_eq($sformatf("tog_gap_%0d", i), im_we, 0);
            end
        end
        finish_load(8'h78, "tog");

        // Restart after 7 bytes; coincident byte is refused
        start_load("rs_req");
        for (int i = 0; i < 7; i++) begin
            send_byte(8'h50 + 8'(i), 4'(i), $sformatf("rs_%0d", i));
        end
        in_valid = 1'b1;
        in_data  = 8'hEE;
        load_req = 1'b1;
        #1;
        check_eq("rs_coincide_rdy", in_ready, 0);
        tick();
        load_req = 1'b0;
        check_eq("rs_coincide_we", im_we, 0);
        check_eq("rs_busy",        busy,  1);
        send_byte(8'h77, 4'd0, "rs_addr0");
        for (int i = 1; i < 8; i++) begin
            send_byte(8'h60 + 8'(i), 4'(i), $sformatf("rs2_%0d", i));
        end

        // Reset during byte 9: outputs clear without waiting for a clock edge
        in_valid = 1'b1;
        in_data  = 8'h99;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_we",    im_we,    0);
        check_eq("arst_addr",  {28'd0, im_addr},  0);
        check_eq("arst_wdata", {24'd0, im_wdata}, 0);
        check_eq("arst_busy",  busy,     0);
        check_eq("arst_rdy",   in_ready, 0);
        check_eq("arst_start", start,    0);
        check_eq("arst_err",   error,    0);
        tick();
        check_eq("arst_edge_we", im_we, 0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq($sformatf("post_rst_we_%0d", i),    im_we,    0);
            check_eq($sformatf("post_rst_start_%0d", i), start,    0);
            check_eq($sformatf("post_rst_rdy_%0d", i),   in_ready, 0);
        end
        in_valid = 1'b0;

`ifdef IM_LOADER_CHECKSUM_EN
        // Sixteen 0x01 bytes plus 0xF0 sum to zero: RUN
        start_load("cs_ok_req");
        for (int i = 0; i < 16; i++) begin
            send_byte(8'h01, 4'(i), $sformatf("cs_ok_%0d", i));
        end
        in_valid = 1'b0;
        check_eq("cs_ok_busy_chk", busy, 1);
        in_valid = 1'b1;
        in_data  = 8'hF0;
        tick();
        in_valid = 1'b0;
        check_eq("cs_ok_no_write", im_we, 0);
        check_eq("cs_ok_err",      error, 0);
        tick();
        check_eq("cs_ok_start", start, 1);
        check_eq("cs_ok_err2",  error, 0);

        // Same program with 0xF1: FAIL with error set, start low
        start_load("cs_bad_req");
        for (int i = 0; i < 16; i++) begin
            send_byte(8'h01, 4'(i), $sformatf("cs_bad_%0d", i));
        end
        in_valid = 1'b1;
        in_data  = 8'hF1;
        tick();
        in_valid = 1'b0;
        check_eq("cs_bad_no_write", im_we, 0);
        check_eq("cs_bad_err",      error, 1);
        check_eq("cs_bad_busy",     busy,  0);
        tick();
        check_eq("cs_bad_err_hold", error, 1);
        check_eq("cs_bad_start",    start, 0);

        // load_req from FAIL drops error on the next edge
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        check_eq("cs_fail_reload_err",  error, 0);
        check_eq("cs_fail_reload_busy", busy,  1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
